// File: rtl/bcd_timer.sv
// BCD stopwatch / countdown timer with HH:MM:SS packed-BCD time, one-second prescaler and load checking.
// Optional lap capture register is built only when LAP_CAPTURE_EN is defined.
module bcd_timer #(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned HR_MAX  = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start_stop,
  input  logic        mode,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        lap,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        tick,
  output logic        done,
  output logic        wrap,
  output logic        load_err,
  output logic [23:0] lap_bcd
);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  localparam logic [31:0] PRESC_LAST = 32'(CLK_DIV - 1);
  localparam logic [3:0]  HR_MAX_H   = 4'(HR_MAX / 10);
  localparam logic [3:0]  HR_MAX_L   = 4'(HR_MAX % 10);
  localparam logic [7:0]  HR_MAX_8   = 8'(HR_MAX);
  localparam logic [23:0] TIME_MAX   = {HR_MAX_H, HR_MAX_L, 4'd5, 4'd9, 4'd5, 4'd9};

  run_state_t  state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [23:0] time_q, time_d;
  logic        tick_d, done_d, wrap_d, load_err_d;
  logic        at_term;
  logic        load_ok;
  logic [7:0]  ld_hours;
  logic [23:0] time_dn;

  // One-second increment with BCD carry; TIME_MAX rolls over to zero.
  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [3:0] hh, hl, mh, ml, sh, sl;
    {hh, hl, mh, ml, sh, sl} = t;
    if (t == TIME_MAX) return '0;
    if (sl != 4'd9) sl = sl + 4'd1;
    else begin
      sl = '0;
      if (sh != 4'd5) sh = sh + 4'd1;
      else begin
        sh = '0;
        if (ml != 4'd9) ml = ml + 4'd1;
        else begin
          ml = '0;
          if (mh != 4'd5) mh = mh + 4'd1;
          else begin
            mh = '0;
            if (hl != 4'd9) hl = hl + 4'd1;
            else begin
              hl = '0;
              hh = hh + 4'd1;
            end
          end
        end
      end
    end
    return {hh, hl, mh, ml, sh, sl};
  endfunction

  // One-second decrement with BCD borrow; zero saturates at zero.
  function automatic logic [23:0] time_dec(input logic [23:0] t);
    logic [3:0] hh, hl, mh, ml, sh, sl;
    {hh, hl, mh, ml, sh, sl} = t;
    if (t == '0) return '0;
    if (sl != 4'd0) sl = sl - 4'd1;
    else begin
      sl = 4'd9;
      if (sh != 4'd0) sh = sh - 4'd1;
      else begin
        sh = 4'd5;
        if (ml != 4'd0) ml = ml - 4'd1;
        else begin
          ml = 4'd9;
          if (mh != 4'd0) mh = mh - 4'd1;
          else begin
            mh = 4'd5;
            if (hl != 4'd0) hl = hl - 4'd1;
            else begin
              hl = 4'd9;
              hh = hh - 4'd1;
            end
          end
        end
      end
    end
    return {hh, hl, mh, ml, sh, sl};
  endfunction

  assign ld_hours = 8'(load_val[23:20]) * 8'd10 + 8'(load_val[19:16]);
  assign load_ok  = (load_val[23:20] <= 4'd9) && (load_val[19:16] <= 4'd9) &&
                    (load_val[15:12] <= 4'd5) && (load_val[11:8]  <= 4'd9) &&
                    (load_val[7:4]   <= 4'd5) && (load_val[3:0]   <= 4'd9) &&
                    (ld_hours <= HR_MAX_8);

  assign at_term = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
  assign time_dn = time_dec(time_q);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    time_d     = time_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      state_d = ST_STOPPED;
      presc_d = '0;
      time_d  = '0;
    end else begin
      if (state_q == ST_RUNNING) presc_d = at_term ? '0 : presc_q + 32'd1;
      tick_d = at_term;
      if (start_stop) begin
        if (state_q == ST_RUNNING) state_d = ST_STOPPED;
        else if (!(mode && (time_q == '0))) state_d = ST_RUNNING;
      end
      if (load) begin
        if (load_ok) begin
          time_d  = load_val;
          presc_d = '0;
        end else begin
          load_err_d = 1'b1;
        end
      end
      // An accepted load overrides the second update that would land on the same edge.
      if (at_term && !(load && load_ok)) begin
        if (!mode) begin
          time_d = time_inc(time_q);
          wrap_d = (time_q == TIME_MAX);
        end else begin
          time_d = time_dn;
          if (time_dn == '0) begin
            done_d  = 1'b1;
            state_d = ST_STOPPED;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STOPPED;
      presc_q  <= '0;
      time_q   <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      tick     <= tick_d;
      done     <= done_d;
      wrap     <= wrap_d;
      load_err <= load_err_d;
    end
  end

  assign time_bcd = time_q;
  assign running  = (state_q == ST_RUNNING);

`ifdef LAP_CAPTURE_EN
  logic [23:0] lap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lap_q <= '0;
    else if (clear) lap_q <= '0;
    else if (lap)   lap_q <= time_q;
  end

  assign lap_bcd = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_bcd    = '0;
`endif

endmodule

// File: tb/tb_bcd_timer.sv
// Self-checking bench for bcd_timer: directed vector table, corner sequences, and a
// randomized run against a seconds-based reference model.
module tb_bcd_timer;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned HR_MAX  = 23;
  localparam int DAY = (HR_MAX + 1) * 3600;
`ifdef LAP_CAPTURE_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clear, start_stop, mode, load, lap;
  logic [23:0] load_val;
  logic [23:0] time_bcd, lap_bcd;
  logic        running, tick, done, wrap, load_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_timer #(.CLK_DIV(CLK_DIV), .HR_MAX(HR_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start_stop(start_stop), .mode(mode),
    .load(load), .load_val(load_val), .lap(lap), .time_bcd(time_bcd), .running(running),
    .tick(tick), .done(done), .wrap(wrap), .load_err(load_err), .lap_bcd(lap_bcd)
  );

  typedef struct {
    logic        clr;
    logic        ss;
    logic        ld;
    logic [23:0] lv;
    logic [23:0] e_time;
    logic        e_run;
    logic        e_tick;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic c, logic ss, logic ld, logic [23:0] lv,
                              logic [23:0] et, logic er, logic etk, logic ee);
    vec_t v;
    v.clr = c; v.ss = ss; v.ld = ld; v.lv = lv;
    v.e_time = et; v.e_run = er; v.e_tick = etk; v.e_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic c, input logic ss, input logic ld, input logic lp,
                       input logic [23:0] lv);
    clear = c; start_stop = ss; load = ld; lap = lp; load_val = lv;
    @(posedge clk);
    #1;
    clear = 1'b0; start_stop = 1'b0; load = 1'b0; lap = 1'b0;
  endtask

  // Reference model: time kept as an integer count of seconds.
  int          m_secs, m_presc;
  bit          m_run;
  logic [23:0] m_lap;
  bit          e_tick, e_done, e_wrap, e_lerr;

  function automatic logic [23:0] to_bcd(int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit load_ok(logic [23:0] v, output int secs);
    int d[6];
    bit ok;
    for (int i = 0; i < 6; i++) d[i] = int'(v[i*4 +: 4]);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) if (d[i] > 9) ok = 1'b0;
    if (d[1] > 5 || d[3] > 5) ok = 1'b0;
    if (d[5] * 10 + d[4] > int'(HR_MAX)) ok = 1'b0;
    secs = (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
    return ok;
  endfunction

  function automatic void model_step(bit c, bit ss, bit md, bit ld, logic [23:0] lv, bit lp);
    bit term, nrun, acc;
    int ls;
    e_tick = 0; e_done = 0; e_wrap = 0; e_lerr = 0;
    if (c) begin
      m_secs = 0; m_presc = 0; m_run = 0; m_lap = '0;
      return;
    end
    if (lp && LAP_ON) m_lap = to_bcd(m_secs);
    term = m_run && (m_presc == int'(CLK_DIV) - 1);
    nrun = m_run;
    if (ss) nrun = m_run ? 1'b0 : !(md && m_secs == 0);
    if (m_run) m_presc = term ? 0 : m_presc + 1;
    e_tick = term;
    acc = 0;
    if (ld) begin
      if (load_ok(lv, ls)) begin
        m_secs = ls; m_presc = 0; acc = 1;
      end else begin
        e_lerr = 1;
      end
    end
    if (term && !acc) begin
      if (!md) begin
        if (m_secs == DAY - 1) begin m_secs = 0; e_wrap = 1; end
        else m_secs++;
      end else begin
        if (m_secs > 0) m_secs--;
        if (m_secs == 0) begin e_done = 1; nrun = 0; end
      end
    end
    m_run = nrun;
  endfunction

  initial begin
    int          ticks, guard;
    bit          seen;
    logic        c, ss, ld, lp;
    logic [23:0] lv;

    rst_n = 1'b0; clear = 1'b0; start_stop = 1'b0; mode = 1'b0;
    load = 1'b0; lap = 1'b0; load_val = '0;

    #12;
    check("rst_time", time_bcd, 0);
    check("rst_running", running, 0);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    check("rst_load_err", load_err, 0);
    check("rst_lap", lap_bcd, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors: start, three ticks, stop, rejected and accepted loads.
    add(1'b0, 1'b1, 1'b0, '0, 24'h000000, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) add(1'b0, 1'b0, 1'b0, '0, 24'(k / 4), 1'b1, (k % 4 == 0), 1'b0);
    add(1'b0, 1'b1, 1'b0, '0, 24'h000003, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 24'h240000, 24'h000003, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, '0, 24'h000003, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 24'h006000, 24'h000003, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 24'h235958, 24'h235958, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].clr, vecs[i].ss, vecs[i].ld, 1'b0, vecs[i].lv);
      check($sformatf("vec%0d_time", i), time_bcd, vecs[i].e_time);
      check($sformatf("vec%0d_running", i), running, vecs[i].e_run);
      check($sformatf("vec%0d_tick", i), tick, vecs[i].e_tick);
      check($sformatf("vec%0d_load_err", i), load_err, vecs[i].e_err);
    end

    // Count-up wrap from 23:59:58.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("wrap_start_running", running, 1);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check($sformatf("wrap_c%0d", k), wrap, (k == 8));
      if (k == 4) check("wrap_t4_time", time_bcd, 24'h235959);
    end
    check("wrap_time", time_bcd, 0);
    check("wrap_running", running, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("wrap_after", wrap, 0);

    // Clear beats load while running.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'h123456);
    check("clrld_time", time_bcd, 0);
    check("clrld_running", running, 0);
    check("clrld_load_err", load_err, 0);
    check("clrld_tick", tick, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'h990000);
    check("clrbad_load_err", load_err, 0);
    check("clrbad_time", time_bcd, 0);
    check("clrbad_running", running, 0);

    // Count-down from 00:01:01 to done.
    mode = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 24'h000101);
    check("dn_load_time", time_bcd, 24'h000101);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("dn_start_running", running, 1);
    ticks = 0; seen = 0;
    for (guard = 0; guard < 300; guard++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (tick) ticks++;
      if (done) begin seen = 1; break; end
    end
    check("dn_done_seen", seen, 1);
    check("dn_ticks", ticks, 61);
    check("dn_time", time_bcd, 0);
    check("dn_running", running, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("dn_done_once", done, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("dn_start_ignored", running, 0);

    // Lap capture at 00:00:05.
    mode = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    seen = 0;
    for (guard = 0; guard < 40; guard++) begin
      if (time_bcd == 24'h000005) begin seen = 1; break; end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    check("lap_reach5", seen, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("lap_capture", lap_bcd, LAP_ON ? 24'h000005 : 24'h0);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("lap_time_continues", time_bcd, 24'h000007);
    check("lap_held", lap_bcd, LAP_ON ? 24'h000005 : 24'h0);

    // Reset mid-count.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #2;
    check("mrst_time", time_bcd, 0);
    check("mrst_running", running, 0);
    check("mrst_tick", tick, 0);
    check("mrst_lap", lap_bcd, 0);
    @(posedge clk);
    #1;
    check("mrst_hold_time", time_bcd, 0);
    check("mrst_hold_tick", tick, 0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("mrst_after_running", running, 0);
    check("mrst_after_time", time_bcd, 0);

    // Randomized run against the reference model.
    m_secs = 0; m_presc = 0; m_run = 0; m_lap = '0;
    for (int n = 0; n < 4000; n++) begin
      c  = ($urandom_range(0, 99) == 0);
      ss = ($urandom_range(0, 9) == 0);
      ld = ($urandom_range(0, 29) == 0);
      lp = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      case ($urandom_range(0, 3))
        0:       lv = 24'($urandom);
        1:       lv = to_bcd(int'($urandom_range(0, DAY - 1)));
        2:       lv = to_bcd(int'($urandom_range(0, 15)));
        default: lv = to_bcd(DAY - 1 - int'($urandom_range(0, 5)));
      endcase
      model_step(c, ss, mode, ld, lv, lp);
      cycle(c, ss, ld, lp, lv);
      check("rnd_time", time_bcd, to_bcd(m_secs));
      check("rnd_running", running, m_run);
      check("rnd_tick", tick, e_tick);
      check("rnd_done", done, e_done);
      check("rnd_wrap", wrap, e_wrap);
      check("rnd_load_err", load_err, e_lerr);
      check("rnd_lap", lap_bcd, m_lap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_timer.md
BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50_000_000, meaning clk cycles per one-second tick (legal range 2..2^32-1).
REQ-002 SHALL have parameter HR_MAX, default 23, meaning maximum hour value in decimal (legal range 1..99).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous clear of time, prescaler and run state.
REQ-006 SHALL have port start_stop, input, 1 bit: single-cycle pulse that toggles the run state.
REQ-007 SHALL have port mode, input, 1 bit: 0 = count up (stopwatch), 1 = count down (timer).
REQ-008 SHALL have port load, input, 1 bit: single-cycle pulse that loads load_val.
REQ-009 SHALL have port load_val, input, 24 bits: packed BCD {hr_h,hr_l,min_h,min_l,sec_h,sec_l}, 4 bits each.
REQ-010 SHALL have port lap, input, 1 bit: pulse that captures the current time (LAP_CAPTURE_EN only).
REQ-011 SHALL have port time_bcd, output, 24 bits: current time, packed as load_val.
REQ-012 SHALL have port running, output, 1 bit: run state.
REQ-013 SHALL have port tick, output, 1 bit: one-cycle pulse on each one-second tick while running.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a count-down reaches 00:00:00.
REQ-015 SHALL have port wrap, output, 1 bit: one-cycle pulse when a count-up rolls from HR_MAX:59:59 to 00:00:00.
REQ-016 SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.
REQ-017 SHALL have port lap_bcd, output, 24 bits: captured lap time (LAP_CAPTURE_EN only).

Function
REQ-018 Prescaler SHALL count 0..CLK_DIV-1 only while running=1; tick SHALL be asserted in the cycle the prescaler equals CLK_DIV-1, and the prescaler SHALL then return to 0.
REQ-019 Prescaler SHALL hold its value while stopped; restart SHALL resume from the held value.
REQ-020 On tick with mode=0, time SHALL increment by 1 s with BCD carry: sec_l 9->0, sec 59->00 carries into minutes, min 59->00 carries into hours, HR_MAX:59:59 -> 00:00:00 with wrap=1 in the same cycle; running SHALL stay 1.
REQ-021 On tick with mode=1, time SHALL decrement by 1 s with BCD borrow (sec 00->59, min 00->59); on reaching 00:00:00, done SHALL be 1 in that cycle and running SHALL go 0 in the same edge.
REQ-022 start_stop while mode=1 and time=00:00:00 SHALL be ignored (running stays 0).
REQ-023 load SHALL be accepted only if every digit is <=9, sec_h<=5, min_h<=5 and hours<=HR_MAX; on acceptance, time_bcd=load_val and prescaler=0, with running unchanged.
REQ-024 A rejected load SHALL leave all state unchanged and pulse load_err for one cycle.
REQ-025 Priority in one cycle SHALL be clear > load > tick update; start_stop SHALL toggle running in the same cycle unless clear is asserted.
REQ-026 clear SHALL set time_bcd=0, prescaler=0 and running=0, and suppress tick, done and wrap in that cycle.
REQ-027 A mode change SHALL take effect at the next tick; the prescaler SHALL NOT be reset by it.
REQ-028 tick, done, wrap and load_err SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-029 While rst_n=0, time_bcd, lap_bcd and the prescaler SHALL be 0, and running, tick, done, wrap and load_err SHALL be 0; a reset mid-count SHALL abandon the count with no pulse emitted.

Configuration
REQ-030 With macro LAP_CAPTURE_EN defined, a lap pulse SHALL copy time_bcd as it stands before that edge's update into lap_bcd; clear SHALL zero lap_bcd; lap SHALL have no effect on counting.
REQ-031 Without LAP_CAPTURE_EN, the lap input SHALL be ignored, lap_bcd SHALL be tied to 0, and no capture register SHALL exist.

Verification (CLK_DIV=4, HR_MAX=23)
REQ-032 Bench SHALL cover: reset, start_stop, 12 cycles -> running=1, 3 tick pulses, time_bcd=00:00:03.
REQ-033 Bench SHALL cover: load 23:59:58, mode=0, run 8 cycles -> time_bcd=00:00:00, wrap=1 for exactly one cycle, running=1.
REQ-034 Bench SHALL cover: load 00:01:01, mode=1, run -> after 61 ticks time_bcd=00:00:00, done=1 for one cycle, running=0; a further start_stop is ignored.
REQ-035 Bench SHALL cover: load 24:00:00 or 00:60:00 -> load_err=1 for one cycle, time_bcd unchanged.
REQ-036 Bench SHALL cover: clear and load in the same cycle while running -> time_bcd=0, running=0, no load_err.
REQ-037 Bench SHALL cover, with LAP_CAPTURE_EN defined: lap at 00:00:05 -> lap_bcd=00:00:05 while time_bcd continues counting; without the macro, lap_bcd stays 0.
